// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the binary-to-BCD converter
//                feeding the 7-segment display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Width of one packed decimal digit
  localparam int BCD_DIGIT_W = 4;

  // Largest legal decimal digit, used to saturate on overflow
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

  // Double-dabble correction: digits at or above 5 get 3 added before a shift
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADD_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADD_OFFSET = 4'd3;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of bits needed to hold any value in 0..max_value
  function automatic int count_bits(input int max_value);
    int w;
    w = 1;
    while ((1 << w) <= max_value) begin
      w++;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_if
//  Description : Request/result bundle between a binary producer and the
//                sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
);

  logic                            start;
  logic [WIDTH-1:0]                bin;
  logic                            ready;
  logic                            done;
  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
  logic                            overflow;

  // Producer side: issues requests and observes results
  modport master (
    output start,
    output bin,
    input  ready,
    input  done,
    input  bcd,
    input  overflow
  );

  // Converter side
  modport slave (
    input  start,
    input  bin,
    output ready,
    output done,
    output bcd,
    output overflow
  );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Single-digit double-dabble correction: adds 3 to a BCD
//                digit that is 5 or more so the following shift carries
//                correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import seg7_pkg::*;
(
  input  wire logic [BCD_DIGIT_W-1:0] din,
  output      logic [BCD_DIGIT_W-1:0] dout
);

  // Conditional +3 correction
  always_comb begin
    dout = din;
    if (din >= BCD_ADD_THRESH) begin
      dout = din + BCD_ADD_OFFSET;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-and-add-3 binary-to-BCD converter. Converts
//                one input bit per clock, holds the last result for the
//                display and saturates to all nines when the value does not
//                fit in DIGITS decimal digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
)(
  input  wire logic   clk,
  input  wire logic   resetn,
  bin2bcd_seq_if.slave bus
);

  // Scratch keeps one extra digit above the visible ones to detect overflow
  localparam int SCR_W = BCD_DIGIT_W * (DIGITS + 1);
  localparam int OUT_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = count_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  // The extra scratch digit can only absorb a limited number of input bits
  if (WIDTH > 3 * (DIGITS + 1)) begin : g_param_check
    $error("bin2bcd_seq: WIDTH=%0d exceeds 3*(DIGITS+1) for DIGITS=%0d", WIDTH, DIGITS);
  end

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;

  logic [SCR_W-1:0]   r_scratch;
  logic [SCR_W-1:0]   w_scratch_adj;
  logic [WIDTH-1:0]   r_binreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_lost;
  logic               w_over;

  logic               r_ready;
  logic               r_done;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_overflow;

  // One +3 corrector per scratch digit, including the overflow digit
  for (genvar gi = 0; gi <= DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (w_scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        // The shift taken with the counter at one is the last input bit
        if (r_cnt == CNT_ONE) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Shift register, scratch digits and bit counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scratch <= '0;
      r_binreg  <= '0;
      r_cnt     <= '0;
      r_lost    <= 1'b0;
    end else if (w_load) begin
      r_scratch <= '0;
      r_binreg  <= bus.bin;
      r_cnt     <= CNT_LOAD;
      r_lost    <= 1'b0;
    end else if (w_shift) begin
      // Binary MSB enters the units digit; a bit leaving the top is remembered
      r_scratch <= {w_scratch_adj[SCR_W-2:0], r_binreg[WIDTH-1]};
      r_binreg  <= r_binreg << 1;
      r_cnt     <= r_cnt - CNT_ONE;
      r_lost    <= r_lost | w_scratch_adj[SCR_W-1];
    end
  end

  // Value does not fit when anything reached the extra digit or beyond
  assign w_over = r_lost | (r_scratch[SCR_W-1 -: BCD_DIGIT_W] != '0);

  // Registered outputs; the result holds between conversions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ready <= (w_state_next == IDLE);
      r_done  <= w_finish;
      if (w_finish) begin
        r_overflow <= w_over;
        r_bcd      <= w_over ? {DIGITS{BCD_NINE}} : r_scratch[OUT_W-1:0];
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Directed self-checking bench for bin2bcd_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  localparam int WIDTH   = 10;
  localparam int DIGITS  = 3;
  localparam int LATENCY = WIDTH + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {ready, done, overflow, bcd}
  function automatic logic [31:0] status();
    return {17'd0, bus.ready, bus.done, bus.overflow, bus.bcd};
  endfunction

  localparam logic [31:0] ST_RESET = {17'd0, 1'b1, 1'b0, 1'b0, 12'h000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge, then scramble bin
  task automatic start_req(input int v);
    bus.start = 1'b1;
    bus.bin   = WIDTH'(v);
    tick();
    bus.start = 1'b0;
    bus.bin   = WIDTH'($urandom);
  endtask

  // Edges counted until done is observed, bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 40);
  endtask

  int vals [4]                = '{123, 0, 999, 1023};
  logic [11:0] exp_bcd [4]    = '{12'h123, 12'h000, 12'h999, 12'h999};
  logic        exp_ovf [4]    = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    int nd;
    bus.start = 1'b0;
    bus.bin   = '0;
    resetn    = 1'b0;
    repeat (3) tick();
    check("reset_status", status(), ST_RESET);
    resetn = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_status", status(), ST_RESET);
    end

    // Directed single conversions
    for (int i = 0; i < 4; i++) begin
      check("ready_before", 32'(bus.ready), 32'd1);
      start_req(vals[i]);
      check("ready_fall", 32'(bus.ready), 32'd0);
      wait_done(n);
      check("latency", 32'(n), 32'(LATENCY));
      check("bcd", 32'(bus.bcd), 32'(exp_bcd[i]));
      check("overflow", 32'(bus.overflow), 32'(exp_ovf[i]));
      check("ready_at_done", 32'(bus.ready), 32'd1);
      tick();
      check("done_single", 32'(bus.done), 32'd0);
      check("bcd_hold", 32'(bus.bcd), 32'(exp_bcd[i]));
    end

    // Request while busy is ignored
    start_req(456);
    tick();
    tick();
    bus.start = 1'b1;
    bus.bin   = WIDTH'(789);
    tick();
    bus.start = 1'b0;
    wait_done(n);
    check("busy_latency", 32'(n), 32'(LATENCY - 3));
    check("busy_bcd", 32'(bus.bcd), 32'h456);
    nd = 0;
    repeat (20) begin
      tick();
      if (bus.done) nd++;
    end
    check("busy_no_second_done", 32'(nd), 32'd0);
    check("busy_bcd_hold", 32'(bus.bcd), 32'h456);

    // Back-to-back: new request in the done cycle
    start_req(321);
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'(LATENCY));
    check("b2b_first_bcd", 32'(bus.bcd), 32'h321);
    check("b2b_ready", 32'(bus.ready), 32'd1);
    start_req(654);
    wait_done(n);
    check("b2b_second_latency", 32'(n), 32'(LATENCY));
    check("b2b_second_bcd", 32'(bus.bcd), 32'h654);

    // Reset in the middle of a conversion
    tick();
    start_req(888);
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    check("midreset_status", status(), ST_RESET);
    tick();
    tick();
    check("midreset_hold", status(), ST_RESET);
    resetn = 1'b1;
    nd = 0;
    repeat (20) begin
      tick();
      if (bus.done) nd++;
    end
    check("midreset_no_done", 32'(nd), 32'd0);
    check("midreset_after", status(), ST_RESET);
    start_req(42);
    wait_done(n);
    check("post_reset_latency", 32'(n), 32'(LATENCY));
    check("post_reset_bcd", 32'(bus.bcd), 32'h042);
    check("post_reset_ovf", 32'(bus.overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
